// File: rtl/pmod_input_pkg.sv
// Shared constants and types for the button/switch input scanner.
package pmod_input_pkg;
    localparam int N_BTN = 4;
    localparam int N_SW  = 4;
    localparam int N_CH  = N_BTN + N_SW;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;
endpackage

// File: rtl/debounce_ch.sv
// One input channel: 2-flop synchronizer, tick-sampled debounce, registered edge pulses.
module debounce_ch #(
    parameter int DEB_N = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_nxt,
    output logic fall_nxt
);
    localparam int CW = $clog2(DEB_N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_N - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          accept;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // rise_nxt/fall_nxt let the repeat FSM act on the same edge that flips level
    assign accept   = tick && (s2 != level) && (cnt == CNT_LAST);
    assign rise_nxt = accept && s2;
    assign fall_nxt = accept && !s2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= rise_nxt;
            fall <= fall_nxt;
            if (tick) begin
                if (s2 == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    level <= s2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/pmod_input_scan.sv
// Button/switch front end: sample-tick divider, 8 debounce channels, per-button auto-repeat.
module pmod_input_scan import pmod_input_pkg::*; #(
    parameter int TICK_W    = 16,
    parameter int DEB_N     = 4,
    parameter int REP_DELAY = 32,
    parameter int REP_RATE  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_BTN-1:0] buttons_i,
    input  logic [N_SW-1:0]  switches_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_release_o,
    output logic [N_BTN-1:0] btn_repeat_o,
    output logic [N_SW-1:0]  sw_level_o,
    output logic [N_SW-1:0]  sw_change_o,
    output logic             tick_o
);
    localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REP_RATE - 1);

    logic [TICK_W-1:0] div;
    logic              tick;
    logic [N_CH-1:0]   raw, level, rise, fall, rise_nxt, fall_nxt;
    logic              unused_sw_nxt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) div <= '0;
        else       div <= div + 1'b1;
    end

    assign tick   = &div;
    assign tick_o = tick;
    assign raw    = {switches_i, buttons_i};

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_ch #(.DEB_N(DEB_N)) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .tick     (tick),
            .raw      (raw[g]),
            .level    (level[g]),
            .rise     (rise[g]),
            .fall     (fall[g]),
            .rise_nxt (rise_nxt[g]),
            .fall_nxt (fall_nxt[g])
        );
    end

    assign btn_level_o   = level[N_BTN-1:0];
    assign btn_press_o   = rise[N_BTN-1:0];
    assign btn_release_o = fall[N_BTN-1:0];
    assign sw_level_o    = level[N_CH-1:N_BTN];
    assign sw_change_o   = rise[N_CH-1:N_BTN] | fall[N_CH-1:N_BTN];
    assign unused_sw_nxt = ^{rise_nxt[N_CH-1:N_BTN], fall_nxt[N_CH-1:N_BTN]};

    for (genvar b = 0; b < N_BTN; b++) begin : g_rep
        rep_state_t    state, state_n;
        logic [RW-1:0] cnt, cnt_n;
        logic          rep, rep_n;

        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            rep_n   = 1'b0;
            case (state)
                IDLE: if (rise_nxt[b]) begin
                    state_n = DELAY;
                    cnt_n   = '0;
                    rep_n   = 1'b1;
                end
                DELAY: if (tick) begin
                    if (cnt == DLY_LAST) begin
                        state_n = REPEAT;
                        cnt_n   = '0;
                        rep_n   = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                REPEAT: if (tick) begin
                    if (cnt == RATE_LAST) begin
                        cnt_n = '0;
                        rep_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
            // a release on the expiry tick suppresses that repeat
            if (fall_nxt[b]) begin
                state_n = IDLE;
                cnt_n   = '0;
                rep_n   = 1'b0;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state <= IDLE;
                cnt   <= '0;
                rep   <= 1'b0;
            end else begin
                state <= state_n;
                cnt   <= cnt_n;
                rep   <= rep_n;
            end
        end

        assign btn_repeat_o[b] = rep;
    end
endmodule

// File: doc/pmod_input_scan.md
# pmod_input_scan

Input-side companion to the PMOD LED / seven-segment output driver: takes the board's raw push-buttons and slide switches, synchronizes and debounces them on a slow sample tick, and emits clean levels plus single-cycle event pulses. Buttons also get keyboard-style auto-repeat, so a held button can step counters. Sits between the top-level pins and any control logic that consumes button/switch state.

## Interface
- `TICK_W`, 16: sample-tick divider width; one tick every 2^TICK_W cycles
- `DEB_N`, 4: consecutive ticks a new value must persist before acceptance (≥1)
- `REP_DELAY`, 32: ticks from press to first auto-repeat (≥1)
- `REP_RATE`, 8: ticks between subsequent auto-repeats (≥1)

- `clk_i` in 1: sole clock
- `rst_i` in 1: reset, asynchronous, active-high
- `buttons_i` in 4: raw button pins, active-high, asynchronous
- `switches_i` in 4: raw switch pins, asynchronous
- `btn_level_o` out 4: debounced button state
- `btn_press_o` out 4: 1-cycle pulse on debounced 0→1
- `btn_release_o` out 4: 1-cycle pulse on debounced 1→0
- `btn_repeat_o` out 4: 1-cycle pulse on press and on each auto-repeat
- `sw_level_o` out 4: debounced switch state
- `sw_change_o` out 4: 1-cycle pulse on any debounced switch transition
- `tick_o` out 1: sample tick strobe

## Operation
- All 8 raw inputs pass through a 2-flop synchronizer (reset 0).
- Tick divider: free-running TICK_W-bit counter, reset 0, wraps; `tick_o` = (counter == all-ones), combinational decode of the register.
- Debounce per channel: registers `stable` (reset 0) and agreement count of width $clog2(DEB_N+1). On tick: if synced sample == stable, count ← 0; else count+1; when the increment would reach DEB_N, stable ← sample, count ← 0. No state change on non-tick cycles.
- Edge pulses registered on the same edge that updates `stable`: press/release/change appear in the first cycle the new level is visible.
- Repeat FSM per button, states IDLE, DELAY, REPEAT, counter width $clog2(max(REP_DELAY,REP_RATE)+1):
  - IDLE: on press → DELAY, cnt ← 0, repeat pulse coincident with press pulse.
  - DELAY: on tick cnt+1; reaching REP_DELAY → pulse, REPEAT, cnt ← 0.
  - REPEAT: on tick cnt+1; reaching REP_RATE → pulse, cnt ← 0.
  - Debounced release in any state → IDLE, cnt ← 0.
- Simultaneous release and repeat expiry on the same tick: release wins, no repeat pulse.
- Switches have no repeat; a switch high at reset exit produces one `sw_change_o` after debounce (intended).

## Timing
- Reset values: every output 0, FSMs IDLE, all counters 0.
- Reset mid-operation: asynchronous clear of everything; no pulse generated by reset or its release.
- Latency: raw edge → synced after 2 cycles; level/pulse update in the cycle after the DEB_N-th tick sampling the new value. Worst case 2 + DEB_N·2^TICK_W cycles.
- Pulses are exactly one cycle, never back-to-back for the same channel (minimum spacing one tick period).
- Bounce shorter than DEB_N ticks never changes the level.

## Structure
- Package `pmod_input_pkg`: `N_BTN` = 4, `N_SW` = 4, `rep_state_t` enum {IDLE, DELAY, REPEAT}.
- Sub-module `debounce_ch`: synchronizer + debounce counter + edge pulses for one bit, inputs `tick`; instantiated 8×. Tick divider and repeat FSMs (generate loop) live in the top.

## Test plan
Parameters TICK_W=2, DEB_N=3, REP_DELAY=4, REP_RATE=2; cycle 0 = first edge after reset release.
- Reset: all outputs 0; `tick_o` high at cycles 3, 7, 11, …
- Clean press `buttons_i[0]` held 1 → `btn_level_o[0]` rises after 3rd tick sampling 1; `btn_press_o[0]`, `btn_repeat_o[0]` single pulse same cycle.
- Bounce: toggle `buttons_i[1]` every tick for 10 ticks, then 0 → level stays 0, no pulses.
- Hold `buttons_i[2]` 40 ticks past press tick P → repeat pulses at P, P+4, P+6, …, P+40 (20 total); release → one `btn_release_o[2]`, no further repeats.
- `switches_i[3]` = 1 through reset → `sw_level_o[3]` rises after 3 ticks, exactly one `sw_change_o[3]`.
- Assert `rst_i` mid-cycle while button 0 in REPEAT → outputs 0 immediately; after release with button still held, press pulse only after full re-debounce.
